// File: rtl/vdp_cpu_port_if.sv
// vdp99 CPU bus bundle: TMS9918-style strobes, port select and data.
// master = CPU side, slave = vdp_cpu_port.
interface vdp_cpu_port_if;
  logic       cpu_wr_tick;
  logic       cpu_rd_tick;
  logic       cpu_mode;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;

  modport master (
    output cpu_wr_tick, cpu_rd_tick,
    output cpu_mode, cpu_din,
    input  cpu_dout
  );

  modport slave (
    input  cpu_wr_tick, cpu_rd_tick,
    input  cpu_mode, cpu_din,
    output cpu_dout
  );
endinterface

// File: rtl/vdp_cpu_port.sv
// vdp99 CPU port: R0-R7, status, VRAM address counter, one-entry buffer.
// Optional overrun counter output enabled by VDP_CPU_OVERRUN_EN.
module vdp_cpu_port #(
  parameter int ADDR_W = 14
) (
  input  logic              pxclk,
  input  logic              reset_n,
  vdp_cpu_port_if.slave     cpu,
  input  logic              cpu_slot,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_din,
  output logic              vram_wr_tick,
  output logic              vram_rd_tick,
  input  logic [7:0]        vram_dout,
  input  logic              frame_tick,
  input  logic              spr_5th_tick,
  input  logic [4:0]        spr_5th_num,
  input  logic              spr_coinc_tick,
  output logic [2:0]        vdp_mode,
  output logic              vdp_blank,
  output logic              vdp_ssiz,
  output logic              vdp_smag,
  output logic [3:0]        vdp_name_base,
  output logic [7:0]        vdp_color_base,
  output logic [2:0]        vdp_pattern_base,
  output logic [6:0]        vdp_sprite_att_base,
  output logic [2:0]        vdp_sprite_pat_base,
  output logic [3:0]        vdp_fg_color,
  output logic [3:0]        vdp_bg_color,
  output logic              irq_n
`ifdef VDP_CPU_OVERRUN_EN
  ,
  output logic [7:0]        cpu_overrun_ctr
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RDW
  } st_t;

  st_t              r_st;
  st_t              w_st_nxt;
  logic [7:0]       r_regs [8];
  logic [7:0]       r_temp;
  logic             r_toggle;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]       r_wbuf;
  logic [7:0]       r_rbuf;
  logic [7:0]       r_dout;
  logic             r_f;
  logic             r_5s;
  logic             r_c;
  logic [4:0]       r_num;

  logic w_wr, w_rd;
  logic w_ctl_wr, w_dat_wr;
  logic w_sts_rd, w_dat_rd;
  logic w_ctl2, w_reg_wr;
  logic w_addr_set, w_ra;
  logic w_busy;
  logic w_vwr, w_vrd, w_cap, w_inc;
  logic [ADDR_W-1:0] w_addr_new;

  // a write in the same cycle masks any read
  assign w_wr       = cpu.cpu_wr_tick;
  assign w_rd       = cpu.cpu_rd_tick & ~cpu.cpu_wr_tick;
  assign w_ctl_wr   = w_wr & cpu.cpu_mode;
  assign w_dat_wr   = w_wr & ~cpu.cpu_mode;
  assign w_sts_rd   = w_rd & cpu.cpu_mode;
  assign w_dat_rd   = w_rd & ~cpu.cpu_mode;
  assign w_ctl2     = w_ctl_wr & r_toggle;
  assign w_reg_wr   = w_ctl2 & (cpu.cpu_din[7:6] == 2'b10);
  assign w_addr_set = w_ctl2 & ~cpu.cpu_din[7];
  assign w_ra       = w_ctl2 & (cpu.cpu_din[7:6] == 2'b00);
  assign w_busy     = (r_st != ST_IDLE);
  assign w_addr_new = ADDR_W'({cpu.cpu_din[5:0], r_temp});

  // pending-access state register
  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) r_st <= ST_IDLE;
    else          r_st <= w_st_nxt;
  end

  // next pending state and VRAM strobes; an address set supersedes all
  always_comb begin
    w_st_nxt = r_st;
    w_vwr    = 1'b0;
    w_vrd    = 1'b0;
    w_cap    = 1'b0;
    w_inc    = 1'b0;
    unique case (r_st)
      ST_IDLE: begin
        if (w_dat_wr)      w_st_nxt = ST_WR;
        else if (w_dat_rd) w_st_nxt = ST_RD;
      end
      ST_WR: begin
        if (cpu_slot) begin
          w_vwr    = 1'b1;
          w_inc    = 1'b1;
          w_st_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        if (cpu_slot) begin
          w_vrd    = 1'b1;
          w_st_nxt = ST_RDW;
        end
      end
      ST_RDW: begin
        w_cap    = 1'b1;
        w_inc    = 1'b1;
        w_st_nxt = ST_IDLE;
      end
    endcase
    if (w_addr_set) begin
      w_st_nxt = w_ra ? ST_RD : ST_IDLE;
      w_vwr    = 1'b0;
      w_vrd    = 1'b0;
      w_cap    = 1'b0;
      w_inc    = 1'b0;
    end
  end

  // control-port two-byte sequencing and register file
  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_toggle <= 1'b0;
      r_temp   <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      if (w_ctl_wr)   r_toggle <= ~r_toggle;
      else if (w_dat_wr | w_rd) r_toggle <= 1'b0;
      if (w_ctl_wr & ~r_toggle) r_temp <= cpu.cpu_din;
      if (w_reg_wr) r_regs[cpu.cpu_din[2:0]] <= r_temp;
    end
  end

  // VRAM address counter, wraps naturally at 2^ADDR_W
  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n)        r_addr <= '0;
    else if (w_addr_set) r_addr <= w_addr_new;
    else if (w_inc)      r_addr <= r_addr + ADDR_W'(1);
  end

  // write buffer, read buffer and registered CPU read data
  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wbuf <= '0;
      r_rbuf <= '0;
      r_dout <= '0;
    end else begin
      if (w_dat_wr & ~w_busy) r_wbuf <= cpu.cpu_din;
      if (w_vwr)      r_rbuf <= r_wbuf;
      else if (w_cap) r_rbuf <= vram_dout;
      if (w_sts_rd)      r_dout <= {r_f, r_5s, r_c, r_num};
      else if (w_dat_rd) r_dout <= r_rbuf;
    end
  end

  // status flags: a set in the same cycle as a read wins
  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_f   <= 1'b0;
      r_5s  <= 1'b0;
      r_c   <= 1'b0;
      r_num <= '0;
    end else begin
      r_f  <= frame_tick     | (r_f  & ~w_sts_rd);
      r_c  <= spr_coinc_tick | (r_c  & ~w_sts_rd);
      r_5s <= spr_5th_tick   | (r_5s & ~w_sts_rd);
      if (spr_5th_tick & ~r_5s) r_num <= spr_5th_num;
    end
  end

`ifdef VDP_CPU_OVERRUN_EN
  logic       w_ovr;
  logic [7:0] r_ovr;
  assign w_ovr = (w_dat_wr | w_dat_rd) & w_busy;

  // saturating count of dropped data-port accesses
  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n)       r_ovr <= '0;
    else if (w_sts_rd)  r_ovr <= {7'd0, w_ovr};
    else if (w_ovr && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
  end

  assign cpu_overrun_ctr = r_ovr;
`endif

  assign cpu.cpu_dout    = r_dout;
  assign vram_addr       = r_addr;
  assign vram_din        = r_wbuf;
  assign vram_wr_tick    = w_vwr;
  assign vram_rd_tick    = w_vrd;

  assign vdp_mode        = {r_regs[0][1], r_regs[1][3], r_regs[1][4]};
  assign vdp_blank       = ~r_regs[1][6];
  assign vdp_ssiz        = r_regs[1][1];
  assign vdp_smag        = r_regs[1][0];
  assign vdp_name_base   = r_regs[2][3:0];
  assign vdp_color_base  = r_regs[3];
  assign vdp_pattern_base    = r_regs[4][2:0];
  assign vdp_sprite_att_base = r_regs[5][6:0];
  assign vdp_sprite_pat_base = r_regs[6][2:0];
  assign vdp_fg_color    = r_regs[7][7:4];
  assign vdp_bg_color    = r_regs[7][3:0];
  assign irq_n           = ~(r_f & r_regs[1][5]);

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_vdp_cpu_port;

  logic        pxclk = 1'b0;
  logic        reset_n;
  logic        cpu_slot;
  logic [13:0] vram_addr;
  logic [7:0]  vram_din;
  logic        vram_wr_tick;
  logic        vram_rd_tick;
  logic [7:0]  vram_dout;
  logic        frame_tick;
  logic        spr_5th_tick;
  logic [4:0]  spr_5th_num;
  logic        spr_coinc_tick;
  logic [2:0]  vdp_mode;
  logic        vdp_blank;
  logic        vdp_ssiz;
  logic        vdp_smag;
  logic [3:0]  vdp_name_base;
  logic [7:0]  vdp_color_base;
  logic [2:0]  vdp_pattern_base;
  logic [6:0]  vdp_sprite_att_base;
  logic [2:0]  vdp_sprite_pat_base;
  logic [3:0]  vdp_fg_color;
  logic [3:0]  vdp_bg_color;
  logic        irq_n;
`ifdef VDP_CPU_OVERRUN_EN
  logic [7:0]  cpu_overrun_ctr;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int bad_tick = 0;

  vdp_cpu_port_if bus ();

  vdp_cpu_port #(.ADDR_W(14)) dut (
    .pxclk               (pxclk),
    .reset_n             (reset_n),
    .cpu                 (bus),
    .cpu_slot            (cpu_slot),
    .vram_addr           (vram_addr),
    .vram_din            (vram_din),
    .vram_wr_tick        (vram_wr_tick),
    .vram_rd_tick        (vram_rd_tick),
    .vram_dout           (vram_dout),
    .frame_tick          (frame_tick),
    .spr_5th_tick        (spr_5th_tick),
    .spr_5th_num         (spr_5th_num),
    .spr_coinc_tick      (spr_coinc_tick),
    .vdp_mode            (vdp_mode),
    .vdp_blank           (vdp_blank),
    .vdp_ssiz            (vdp_ssiz),
    .vdp_smag            (vdp_smag),
    .vdp_name_base       (vdp_name_base),
    .vdp_color_base      (vdp_color_base),
    .vdp_pattern_base    (vdp_pattern_base),
    .vdp_sprite_att_base (vdp_sprite_att_base),
    .vdp_sprite_pat_base (vdp_sprite_pat_base),
    .vdp_fg_color        (vdp_fg_color),
    .vdp_bg_color        (vdp_bg_color),
    .irq_n               (irq_n)
`ifdef VDP_CPU_OVERRUN_EN
    ,
    .cpu_overrun_ctr     (cpu_overrun_ctr)
`endif
  );

  always #5 pxclk = ~pxclk;

  always @(posedge pxclk) begin
    if (vram_wr_tick) wr_cnt++;
    if ((vram_wr_tick | vram_rd_tick) & ~cpu_slot) bad_tick++;
  end

  task automatic tick();
    @(posedge pxclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cwr(input logic m, input logic [7:0] d);
    bus.cpu_wr_tick = 1'b1;
    bus.cpu_mode    = m;
    bus.cpu_din     = d;
    tick();
    bus.cpu_wr_tick = 1'b0;
  endtask

  task automatic crd(input logic m);
    bus.cpu_rd_tick = 1'b1;
    bus.cpu_mode    = m;
    tick();
    bus.cpu_rd_tick = 1'b0;
  endtask

  // one slot with a pending write; checks strobe, address and data
  task automatic serve_wr(input string tag,
                          input logic [13:0] a,
                          input logic [7:0] d);
    cpu_slot = 1'b1;
    #1;
    chk({tag, "_wr"}, 32'(vram_wr_tick), 32'd1);
    chk({tag, "_addr"}, 32'(vram_addr), 32'(a));
    chk({tag, "_din"}, 32'(vram_din), 32'(d));
    tick();
    cpu_slot = 1'b0;
  endtask

  // one slot with a pending read, then VRAM data in the next cycle
  task automatic serve_rd(input string tag,
                          input logic [13:0] a,
                          input logic [7:0] d);
    cpu_slot = 1'b1;
    #1;
    chk({tag, "_rd"}, 32'(vram_rd_tick), 32'd1);
    chk({tag, "_addr"}, 32'(vram_addr), 32'(a));
    tick();
    cpu_slot  = 1'b0;
    vram_dout = d;
    tick();
    vram_dout = 8'h00;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.cpu_wr_tick = 1'b0;
    bus.cpu_rd_tick = 1'b0;
    bus.cpu_mode   = 1'b0;
    bus.cpu_din    = 8'h00;
    cpu_slot       = 1'b0;
    vram_dout      = 8'h00;
    frame_tick     = 1'b0;
    spr_5th_tick   = 1'b0;
    spr_5th_num    = 5'd0;
    spr_coinc_tick = 1'b0;
    repeat (3) tick();

    chk("rst_dout", 32'(bus.cpu_dout), 32'h00);
    chk("rst_wr", 32'(vram_wr_tick), 32'd0);
    chk("rst_rd", 32'(vram_rd_tick), 32'd0);
    chk("rst_blank", 32'(vdp_blank), 32'd1);
    chk("rst_irq", 32'(irq_n), 32'd1);
    chk("rst_addr", 32'(vram_addr), 32'h0);
    reset_n = 1'b1;
    tick();

    // registers
    cwr(1'b1, 8'hC0);
    chk("r1_half", 32'(vdp_blank), 32'd1);
    cwr(1'b1, 8'h81);
    chk("r1_blank", 32'(vdp_blank), 32'd0);
    chk("r1_mode", 32'(vdp_mode), 32'd0);
    chk("r1_irq", 32'(irq_n), 32'd1);
    cwr(1'b1, 8'h20);
    cwr(1'b1, 8'h81);
    chk("r1_blank2", 32'(vdp_blank), 32'd1);
    cwr(1'b1, 8'hA5);
    cwr(1'b1, 8'h87);
    chk("r7_fg", 32'(vdp_fg_color), 32'hA);
    chk("r7_bg", 32'(vdp_bg_color), 32'h5);
    cwr(1'b1, 8'h1F);
    cwr(1'b1, 8'h82);
    chk("r2_name", 32'(vdp_name_base), 32'hF);
    cwr(1'b1, 8'h02);
    cwr(1'b1, 8'h80);
    chk("r0_mode", 32'(vdp_mode), 32'h4);

    // VRAM write
    cwr(1'b1, 8'h01);
    cwr(1'b1, 8'h48);
    chk("aset_addr", 32'(vram_addr), 32'h0801);
    cwr(1'b0, 8'h5A);
    chk("wr_noslot", 32'(vram_wr_tick), 32'd0);
    serve_wr("w1", 14'h0801, 8'h5A);
    chk("w1_inc", 32'(vram_addr), 32'h0802);
    chk("w1_cnt", 32'(wr_cnt), 32'd1);
    crd(1'b0);
    chk("w1_thru", 32'(bus.cpu_dout), 32'h5A);
    serve_rd("r0", 14'h0802, 8'h77);
    chk("r0_inc", 32'(vram_addr), 32'h0803);

    // read-ahead and wrap
    cwr(1'b1, 8'hFF);
    cwr(1'b1, 8'h3F);
    serve_rd("ra", 14'h3FFF, 8'h33);
    chk("ra_wrap", 32'(vram_addr), 32'h0000);
    crd(1'b0);
    chk("ra_data", 32'(bus.cpu_dout), 32'h33);
    serve_rd("ra2", 14'h0000, 8'h44);
    chk("ra2_inc", 32'(vram_addr), 32'h0001);

    // frame interrupt
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("irq_set", 32'(irq_n), 32'd0);
    crd(1'b1);
    chk("sts_f", 32'(bus.cpu_dout), 32'h80);
    chk("irq_clr", 32'(irq_n), 32'd1);
    frame_tick = 1'b1;
    crd(1'b1);
    frame_tick = 1'b0;
    chk("sts_race", 32'(bus.cpu_dout), 32'h00);
    chk("irq_race", 32'(irq_n), 32'd0);
    crd(1'b1);
    chk("sts_f2", 32'(bus.cpu_dout), 32'h80);
    chk("irq_clr2", 32'(irq_n), 32'd1);

    // sprite flags
    spr_5th_tick = 1'b1;
    spr_5th_num  = 5'h15;
    tick();
    spr_5th_num  = 5'h03;
    spr_coinc_tick = 1'b1;
    tick();
    spr_5th_tick = 1'b0;
    spr_coinc_tick = 1'b0;
    crd(1'b1);
    chk("sts_spr", 32'(bus.cpu_dout), 32'h75);
    crd(1'b1);
    chk("sts_clr", 32'(bus.cpu_dout), 32'h15);

    // overrun
    cwr(1'b0, 8'h11);
    cwr(1'b0, 8'h22);
    serve_wr("ov", 14'h0001, 8'h11);
    cpu_slot = 1'b1;
    #1;
    chk("ov_drop", 32'(vram_wr_tick), 32'd0);
    tick();
    cpu_slot = 1'b0;
    chk("ov_cnt", 32'(wr_cnt), 32'd2);
`ifdef VDP_CPU_OVERRUN_EN
    chk("ovc_1", 32'(cpu_overrun_ctr), 32'd1);
    crd(1'b1);
    chk("ovc_clr", 32'(cpu_overrun_ctr), 32'd0);
`endif
    cwr(1'b0, 8'h66);
    crd(1'b0);
    chk("ov_rd", 32'(bus.cpu_dout), 32'h11);
`ifdef VDP_CPU_OVERRUN_EN
    chk("ovc_rd", 32'(cpu_overrun_ctr), 32'd1);
`endif
    serve_wr("ov2", 14'h0002, 8'h66);

    // toggle cleared by status read
    cwr(1'b1, 8'h55);
    crd(1'b1);
    chk("tg_sts", 32'(bus.cpu_dout), 32'h15);
    cwr(1'b1, 8'h00);
    cwr(1'b1, 8'h40);
    chk("tg_addr", 32'(vram_addr), 32'h0000);
    chk("tg_mode", 32'(vdp_mode), 32'h4);
    cpu_slot = 1'b1;
    #1;
    chk("tg_nord", 32'(vram_rd_tick), 32'd0);
    tick();
    cpu_slot = 1'b0;
    cwr(1'b0, 8'h99);
    serve_wr("tg", 14'h0000, 8'h99);

    // write and read together
    bus.cpu_rd_tick = 1'b1;
    cwr(1'b0, 8'hAB);
    bus.cpu_rd_tick = 1'b0;
    chk("wr_rd_dout", 32'(bus.cpu_dout), 32'h15);
    serve_wr("wrrd", 14'h0001, 8'hAB);
    chk("wr_total", 32'(wr_cnt), 32'd5);

    // reset mid-operation
    cwr(1'b0, 8'hCD);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    cpu_slot = 1'b1;
    #1;
    chk("mr_nowr", 32'(vram_wr_tick), 32'd0);
    chk("mr_addr", 32'(vram_addr), 32'h0);
    tick();
    cpu_slot = 1'b0;
    chk("mr_blank", 32'(vdp_blank), 32'd1);
    chk("mr_dout", 32'(bus.cpu_dout), 32'h00);
    chk("mr_cnt", 32'(wr_cnt), 32'd5);
    chk("slot_only", 32'(bad_tick), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
- CPU-facing side of the vdp99 VDP: TMS9918-style data/control ports, register file R0–R7, status register, VRAM address counter, one-entry read-ahead/write buffer.
- Sits upstream of vdp_fsm and drives its configuration inputs (vdp_mode, vdp_blank, bases, colours).
- Performs CPU VRAM accesses only in the CPU slot of vdp_fsm's 8-phase tile cycle.

Parameters:
- ADDR_W, 14, VRAM address width; the counter wraps modulo 2^ADDR_W.

Ports:
- pxclk  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_wr_tick  in  1  one-cycle CPU write strobe, already synchronized to pxclk.
- cpu_rd_tick  in  1  one-cycle CPU read strobe, already synchronized to pxclk.
- cpu_mode  in  1  port select: 0 = data, 1 = control/status.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data, registered.
- cpu_slot  in  1  high for the one cycle per tile in which the CPU may use VRAM.
- vram_addr  out  ADDR_W  CPU VRAM address.
- vram_din  out  8  VRAM write data.
- vram_wr_tick  out  1  VRAM write strobe.
- vram_rd_tick  out  1  VRAM read strobe.
- vram_dout  in  8  VRAM read data.
- frame_tick  in  1  start of vertical blank.
- spr_5th_tick  in  1  fifth-sprite event from the sprite engine.
- spr_5th_num  in  5  sprite number associated with spr_5th_tick.
- spr_coinc_tick  in  1  sprite coincidence event.
- vdp_mode  out  3  {R0[1], R1[3], R1[4]} = {M3, M2, M1}.
- vdp_blank  out  1  ~R1[6].
- vdp_ssiz  out  1  R1[1].
- vdp_smag  out  1  R1[0].
- vdp_name_base  out  4  R2[3:0].
- vdp_color_base  out  8  R3.
- vdp_pattern_base  out  3  R4[2:0].
- vdp_sprite_att_base  out  7  R5[6:0].
- vdp_sprite_pat_base  out  3  R6[2:0].
- vdp_fg_color  out  4  R7[7:4].
- vdp_bg_color  out  4  R7[3:0].
- irq_n  out  1  ~(F & R1[5]).

Behaviour:
- Reset: R0–R7 = 0, status = 0, address = 0, toggle = 0, pending = NONE, read buffer = 0.
  - Resulting outputs: cpu_dout = 0, vram ticks = 0, vdp_blank = 1, irq_n = 1.
  - Reset asserted mid-operation discards any pending access.
- Control write, toggle = 0: latch cpu_din into temp; toggle = 1.
- Control write, toggle = 1 (toggle then returns to 0), decoded on cpu_din[7:6]:
  - 10: R[cpu_din[2:0]] <= temp. The register outputs update on the next edge.
  - 01: addr <= {cpu_din[5:0], temp}; no VRAM access.
  - 00: addr <= {cpu_din[5:0], temp}; pending = READ (read-ahead).
  - 11: ignored.
- Status read (control port):
  - cpu_dout <= {F, 5S, C, num[4:0]}.
  - Then F, 5S and C are cleared, and toggle = 0.
- Data write:
  - toggle = 0.
  - wbuf <= cpu_din; pending = WRITE.
- Data read:
  - toggle = 0.
  - cpu_dout <= read buffer.
  - pending = READ.
- cpu_dout updates on the edge after the rd tick and holds until the next read.
- Pending service, on the first cycle with cpu_slot = 1:
  - WRITE: vram_wr_tick = 1, vram_addr = addr, vram_din = wbuf. On the same edge, read buffer <= wbuf and addr <= addr + 1.
  - READ: vram_rd_tick = 1, vram_addr = addr. vram_dout is captured into the read buffer on the edge ending the following cycle; addr <= addr + 1 on that same edge.
  - pending = NONE once the access completes.
  - vram_wr_tick and vram_rd_tick are never high outside cpu_slot.
- Address wrap: 2^ADDR_W − 1 increments to 0.
- Status flags:
  - frame_tick sets F.
  - spr_coinc_tick sets C.
  - spr_5th_tick sets 5S; num is loaded only if 5S was clear.
  - A set and a status read in the same cycle: the read returns the pre-set value and the flag stays set (set wins).
- A data-port access while pending ≠ NONE is an overrun:
  - The new access is dropped and toggle is still cleared.
  - For a dropped read, cpu_dout still returns the current read buffer.
- cpu_wr_tick and cpu_rd_tick in the same cycle: the write is honoured and the read is ignored.

Optional Feature:
- VDP_CPU_OVERRUN_EN defined:
  - Adds output cpu_overrun_ctr [7:0]: counts dropped data-port accesses, saturates at 0xFF, reset 0, cleared by a status read.
  - An overrun and a status read in the same cycle leave the counter at 1.
- Undefined: the port is absent and overruns are dropped silently.

Test Plan:
- Reset: control writes 0xC0 then 0x81 -> R1 = 0xC0; next cycle vdp_blank = 0 and vdp_mode = 0. Writing 0x20 then 0x81 -> vdp_blank = 1.
- Control writes 0x01 then 0x48; data write 0x5A; cpu_slot pulses -> exactly one vram_wr_tick with vram_addr = 0x0801, vram_din = 0x5A; addr becomes 0x0802.
- Control writes 0xFF then 0x3F (read-ahead at 0x3FFF); vram_dout = 0x33 in the cycle after vram_rd_tick -> data read returns 0x33; the next read access uses vram_addr = 0x0000 (wrap).
- Set R1 = 0x20, then pulse frame_tick -> irq_n = 0; status read returns 0x80 and irq_n = 1 on the next cycle. frame_tick coincident with a status read -> returns 0x00 and irq_n stays 0.
- Two data writes with no cpu_slot between them -> only the first is written to VRAM; cpu_overrun_ctr = 1 when VDP_CPU_OVERRUN_EN is defined.
- Single control write, then a status read, then control writes 0x00 and 0x40 -> register write is not taken; address = 0x4000 & (2^ADDR_W − 1) = 0x0000; write mode.
